// File: rtl/rf_hazard_unit_pkg.sv
// Shared types and constants for the register-file hazard unit:
// forwarding-select encodings, the per-stage destination tag and the PC index.
package rf_hazard_unit_pkg;

  localparam int TAG_RBITS = 4;
  localparam logic [TAG_RBITS-1:0] PC_IDX = 4'd15;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_RBITS-1:0] rd;
    logic                 load;
  } tag_t;

  // R15 reads come from the PC path, so they can never match a pending write.
  function automatic logic tag_hit(input tag_t t, input logic [TAG_RBITS-1:0] src,
                                   input logic used);
    return used && t.valid && (t.rd == src) && (src != PC_IDX);
  endfunction

endpackage

// File: rtl/rf_hazard_unit_fwd_sel.sv
// Per-read-port resolver: picks the youngest in-flight producer of one source
// and flags a hazard that the pipeline must stall on.
module rf_fwd_sel
  import rf_hazard_unit_pkg::*;
#(
  parameter logic FWD_EN = 1'b1
) (
  input  logic [TAG_RBITS-1:0] src,
  input  logic                 used,
  input  tag_t                 ex,
  input  tag_t                 mem,
  input  tag_t                 wb,
  output logic [1:0]           sel,
  output logic                 hazard
);

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;
  logic unused_loads;

  assign hit_ex       = tag_hit(ex, src, used);
  assign hit_mem      = tag_hit(mem, src, used);
  assign hit_wb       = tag_hit(wb, src, used);
  assign unused_loads = mem.load ^ wb.load;

  // Without forwarding every RAW dependence waits until the writer leaves WB.
  always_comb begin
    sel    = FWD_RF;
    hazard = 1'b0;
    if (FWD_EN) begin
      if (hit_ex)
        sel = FWD_EX;
      else if (hit_mem)
        sel = FWD_MEM;
      else if (hit_wb)
        sel = FWD_WB;
      hazard = hit_ex && ex.load;
    end else begin
      hazard = hit_ex || hit_mem || hit_wb;
    end
  end

endmodule

// File: rtl/rf_hazard_unit.sv
// Hazard unit for the 5-stage pipeline: shadows destination tags through
// EX/MEM/WB, drives forwarding selects, stalls/bubbles and the RF write port.
module rf_hazard_unit
  import rf_hazard_unit_pkg::*;
#(
  parameter logic FWD_EN = 1'b1,
  parameter int   RBITS  = TAG_RBITS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [RBITS-1:0] ID_SA,
  input  logic [RBITS-1:0] ID_SB,
  input  logic [RBITS-1:0] ID_SD,
  input  logic [2:0]       ID_USE,
  input  logic [RBITS-1:0] ID_RD,
  input  logic             ID_WE,
  input  logic             ID_LOAD,
  input  logic             FLUSH,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic [1:0]       FWD_D,
  output logic             HZPCld,
  output logic             IFID_LD,
  output logic             BUBBLE,
  output logic             RFLd,
  output logic [RBITS-1:0] C,
  output logic [15:0]      STALL_CNT
);

  tag_t       ex_tag;
  tag_t       mem_tag;
  tag_t       wb_tag;
  logic [2:0] hazard;
  logic       stall;

  rf_fwd_sel #(.FWD_EN(FWD_EN)) u_sel_a (
    .src(ID_SA), .used(ID_USE[0]), .ex(ex_tag), .mem(mem_tag), .wb(wb_tag),
    .sel(FWD_A), .hazard(hazard[0])
  );

  rf_fwd_sel #(.FWD_EN(FWD_EN)) u_sel_b (
    .src(ID_SB), .used(ID_USE[1]), .ex(ex_tag), .mem(mem_tag), .wb(wb_tag),
    .sel(FWD_B), .hazard(hazard[1])
  );

  rf_fwd_sel #(.FWD_EN(FWD_EN)) u_sel_d (
    .src(ID_SD), .used(ID_USE[2]), .ex(ex_tag), .mem(mem_tag), .wb(wb_tag),
    .sel(FWD_D), .hazard(hazard[2])
  );

  // A flush overrides a stall: the front end must fetch the branch target.
  assign stall   = |hazard;
  assign BUBBLE  = stall | FLUSH;
  assign HZPCld  = FLUSH | ~stall;
  assign IFID_LD = FLUSH | ~stall;

  assign RFLd = wb_tag.valid;
  assign C    = wb_tag.valid ? wb_tag.rd : '0;

  // Killed or stalled ID instructions enter EX as an invalid tag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_tag  <= '0;
      mem_tag <= '0;
      wb_tag  <= '0;
    end else begin
      ex_tag  <= '{valid: ID_WE & ~BUBBLE, rd: ID_RD, load: ID_LOAD};
      mem_tag <= ex_tag;
      wb_tag  <= mem_tag;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      STALL_CNT <= '0;
    else if (stall && !FLUSH && (STALL_CNT != 16'hFFFF))
      STALL_CNT <= STALL_CNT + 16'd1;
  end

endmodule

// File: doc/rf_hazard_unit.md
Name: rf_hazard_unit

Overview:
- Sequences access to the 16x32 register file (R0–R14 plus the R15 PC register) for the 5-stage pipeline.
- Tracks pending destination registers through EX/MEM/WB in a shadow tag pipeline.
- Generates per-read-port forwarding selects, load-use stalls and bubbles, and drives the file's write port (RFLd, C) and PC load enable (HZPCld).
- Sits between the ID-stage decoder and the register file / forwarding muxes.

Parameters:
- FWD_EN, 1: 1 = forward from EX/MEM/WB; 0 = stall on any RAW hazard until the writer retires.
- RBITS, 4: register-index width (16 registers).

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- ID_SA  in  RBITS  port-A source index
- ID_SB  in  RBITS  port-B source index
- ID_SD  in  RBITS  port-D source index (store data)
- ID_USE  in  3  valid bits {D,B,A} for the sources
- ID_RD  in  RBITS  destination index of the ID instruction
- ID_WE  in  1  ID instruction writes a register
- ID_LOAD  in  1  ID instruction is a load
- FLUSH  in  1  taken branch: kill ID and EX entries
- FWD_A  out  2  port-A select: 00 RF, 01 EX, 10 MEM, 11 WB
- FWD_B  out  2  port-B select, same encoding
- FWD_D  out  2  port-D select, same encoding
- HZPCld  out  1  PC register load enable
- IFID_LD  out  1  IF/ID pipeline register load enable
- BUBBLE  out  1  force NOP into ID/EX
- RFLd  out  1  register file write enable (WB)
- C  out  RBITS  register file write index (WB)
- STALL_CNT  out  16  saturating count of stall cycles

Behaviour:
- Tag pipeline: three registers EX, MEM, WB, each holding {valid, rd, load}, advanced every CLK.
  - ID→EX loads {ID_WE, ID_RD, ID_LOAD}.
  - ID→EX loads valid=0 when BUBBLE or FLUSH is asserted.
  - EX→MEM and MEM→WB shift unconditionally.
- Reset (asynchronous, while RST=1): all tag valid bits=0 and STALL_CNT=0. Combinational outputs then evaluate to FWD_*=00, HZPCld=1, IFID_LD=1, BUBBLE=0, RFLd=0, C=0.
- Write port: RFLd = WB.valid; C = WB.rd when WB.valid, else 0. The register file writes at the next posedge.
- Match rule: a source matches a stage when its USE bit is 1, the stage is valid, stage.rd == source index, and the source index != 15.
  - R15 reads are never forwarded and never stall; the datapath supplies the PC for R15 reads.
- Forwarding (FWD_EN=1):
  - Select the youngest match, with priority EX > MEM > WB; no match gives 00.
  - WB forwarding is needed because the register file write lands after the ID read.
- Load-use hazard: any source matches EX with EX.load=1. In that cycle, STALL=1.
  - While STALL=1, that source's FWD value is don't-care.
  - The following cycle the load is in MEM and forwards with 10; exactly 1 stall cycle.
- FWD_EN=0: STALL=1 on any match in EX, MEM or WB; FWD_*=00 always.
  - Worst case is 3 consecutive stall cycles, after which the value is read from the file.
- STALL effects: HZPCld=0, IFID_LD=0, BUBBLE=1.
- FLUSH: HZPCld=1, IFID_LD=1, BUBBLE=1. FLUSH has priority over STALL; a flush cycle never counts as a stall.
- STALL_CNT: increments on each cycle where STALL=1 and FLUSH=0; saturates at 0xFFFF.
- ID_WE=0 instructions never create matches, even with a nonzero ID_RD.
- RST asserted mid-stall: tags are cleared immediately, so the stall drops in the same cycle (the outputs are combinational from the tags).
- Multiple sources hit different stages: each port's select is resolved independently. The stall is the OR over all sources.

Decomposition:
- Shared package holds:
  - FWD_RF/FWD_EX/FWD_MEM/FWD_WB encodings
  - the tag struct {valid, rd, load}
  - the PC_IDX=15 constant
- One sub-module, rf_fwd_sel, is instantiated three times (A/B/D). It takes one source plus the three tags and returns a 2-bit select and a 1-bit load-use/RAW flag.

Test Plan:
1. Back-to-back ALU ops: R1←, then read SA=1 next cycle → FWD_A=01; at +2 cycles 10; at +3 cycles 11; at +4 cycles 00. No stall.
2. Load R2, then SB=2 immediately → one cycle with HZPCld=0, IFID_LD=0, BUBBLE=1, STALL_CNT=1; next cycle FWD_B=10. With EX invalid, no stall.
3. SA=5 while EX.rd=5 and MEM.rd=5 → FWD_A=01 (youngest wins). Reading R15 while EX.rd=15 → FWD_A=00, no stall.
4. FLUSH during a load-use hazard → BUBBLE=1, HZPCld=1, STALL_CNT unchanged. The killed EX entry never sets RFLd.
5. FWD_EN=0, R3 write then SD=3 → 3 stall cycles, then FWD_D=00. RFLd=1 with C=3 occurs exactly once.
6. RST pulse mid-stall → outputs return to reset values asynchronously, STALL_CNT=0. Then 70000 forced stalls → STALL_CNT=0xFFFF.
